// File: rtl/slave_fsm_if.sv
// Handshake and read-port bundle between a req/ack byte master and slave_fsm.
// The master side drives req/data/stall and the buffer read address; the
// slave side returns ack, status, checksum and buffer read data.
interface slave_fsm_if #(
  parameter int CNT_W = 2
);
  logic             req;
  logic [7:0]       data;
  logic             stall;
  logic             ack;
  logic [7:0]       last_byte;
  logic [CNT_W-1:0] byte_cnt;
  logic             burst_done;
  logic [7:0]       checksum;
  logic             proto_err;
  logic [CNT_W-1:0] rd_addr;
  logic [7:0]       rd_data;

  modport master (
    output req, data, stall, rd_addr,
    input  ack, last_byte, byte_cnt, burst_done, checksum, proto_err, rd_data
  );

  modport slave (
    input  req, data, stall, rd_addr,
    output ack, last_byte, byte_cnt, burst_done, checksum, proto_err, rd_data
  );
endinterface

// File: rtl/slave_fsm.sv
// Responder for the 4-phase req/ack byte link.
// Each accepted byte is written into a small burst buffer and folded into a
// running XOR. Ack rises ACK_DELAY cycles after capture (plus one register
// stage) and follows req low. When the last byte of a burst completes, a
// one-cycle burst_done pulse is raised and the XOR is published as checksum.
// A master that drops req while the ack is still being delayed gets a
// proto_err pulse; that byte does not count and its XOR contribution is undone.
module slave_fsm #(
  parameter int BURST_BYTES = 4,
  parameter int CNT_W       = 2,
  parameter int ACK_DELAY   = 0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  slave_fsm_if.slave bus
);

  typedef enum logic [1:0] {
    S0_IDLE    = 2'd0,
    S1_DELAY   = 2'd1,
    S2_ACK     = 2'd2,
    S3_RELEASE = 2'd3
  } state_e;

  // Final delay count before moving to the ack state; unused when ACK_DELAY is 0.
  localparam logic [3:0]       DLY_LAST = (ACK_DELAY == 0) ? 4'd0 : 4'(ACK_DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_BYTES - 1);
  localparam logic [CNT_W:0]   DEPTH    = (CNT_W + 1)'(BURST_BYTES);

  // Running-checksum update: the first byte of a burst restarts the fold.
  function automatic logic [7:0] xor_accum(input logic [7:0] acc,
                                           input logic [7:0] b,
                                           input logic       restart);
    logic [7:0] res;
    if (restart) begin
      res = b;
    end else begin
      res = acc ^ b;
    end
    return res;
  endfunction

  state_e           state_q,      state_d;
  logic [3:0]       dly_q,        dly_d;
  logic             ack_q,        ack_d;
  logic             burst_done_q, burst_done_d;
  logic             proto_err_q,  proto_err_d;
  logic [7:0]       last_byte_q,  last_byte_d;
  logic [CNT_W-1:0] byte_cnt_q,   byte_cnt_d;
  logic [7:0]       checksum_q,   checksum_d;
  logic [7:0]       xor_q,        xor_d;
  logic [7:0]       mem_q [BURST_BYTES];
  logic [7:0]       mem_d [BURST_BYTES];
  logic [7:0]       rd_data_s;

  // State and datapath registers; reset clears the buffer and drops ack at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S0_IDLE;
      dly_q        <= 4'd0;
      ack_q        <= 1'b0;
      burst_done_q <= 1'b0;
      proto_err_q  <= 1'b0;
      last_byte_q  <= 8'h00;
      byte_cnt_q   <= '0;
      checksum_q   <= 8'h00;
      xor_q        <= 8'h00;
      for (int i = 0; i < BURST_BYTES; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      state_q      <= state_d;
      dly_q        <= dly_d;
      ack_q        <= ack_d;
      burst_done_q <= burst_done_d;
      proto_err_q  <= proto_err_d;
      last_byte_q  <= last_byte_d;
      byte_cnt_q   <= byte_cnt_d;
      checksum_q   <= checksum_d;
      xor_q        <= xor_d;
      for (int i = 0; i < BURST_BYTES; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Next-state and next-output logic for the handshake FSM and its datapath.
  always_comb begin
    state_d      = state_q;
    dly_d        = dly_q;
    ack_d        = 1'b0;
    burst_done_d = 1'b0;
    proto_err_d  = 1'b0;
    last_byte_d  = last_byte_q;
    byte_cnt_d   = byte_cnt_q;
    checksum_d   = checksum_q;
    xor_d        = xor_q;
    for (int i = 0; i < BURST_BYTES; i++) begin
      mem_d[i] = mem_q[i];
    end

    case (state_q)
      S0_IDLE: begin
        // stall gates capture only here; once a byte is taken it runs to completion
        if (bus.req && !bus.stall) begin
          mem_d[byte_cnt_q] = bus.data;
          last_byte_d       = bus.data;
          xor_d             = xor_accum(xor_q, bus.data, (byte_cnt_q == '0));
          if (ACK_DELAY == 0) begin
            state_d = S2_ACK;
          end else begin
            state_d = S1_DELAY;
            dly_d   = 4'd0;
          end
        end else begin
          state_d = S0_IDLE;
        end
      end

      S1_DELAY: begin
        if (!bus.req) begin
          // Abandoned byte: buffer/last_byte keep it, but it leaves the checksum.
          proto_err_d = 1'b1;
          xor_d       = xor_q ^ last_byte_q;
          state_d     = S0_IDLE;
        end else if (dly_q == DLY_LAST) begin
          state_d = S2_ACK;
        end else begin
          dly_d = dly_q + 4'd1;
        end
      end

      S2_ACK: begin
        if (bus.req) begin
          ack_d = 1'b1;
        end else begin
          state_d = S3_RELEASE;
          if (byte_cnt_q == CNT_LAST) begin
            byte_cnt_d   = '0;
            burst_done_d = 1'b1;
            checksum_d   = xor_q;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end

      S3_RELEASE: begin
        // Forced ack-low gap; a req already high is taken on the next cycle.
        state_d = S0_IDLE;
      end

      default: begin
        state_d = S0_IDLE;
      end
    endcase
  end

  // Side read port into the burst buffer; addresses past the buffer read as zero.
  always_comb begin
    rd_data_s = 8'h00;
    if ({1'b0, bus.rd_addr} < DEPTH) begin
      rd_data_s = mem_q[bus.rd_addr];
    end else begin
      rd_data_s = 8'h00;
    end
  end

  assign bus.ack        = ack_q;
  assign bus.burst_done = burst_done_q;
  assign bus.proto_err  = proto_err_q;
  assign bus.last_byte  = last_byte_q;
  assign bus.byte_cnt   = byte_cnt_q;
  assign bus.checksum   = checksum_q;
  assign bus.rd_data    = rd_data_s;

endmodule
